// File: rtl/dac_seq_pkg.sv
// Shared types and raster constants for the VGA DAC scan sequencer.
package dac_seq_pkg;

  typedef enum logic [1:0] {OFF, SETTLE, RUN} state_t;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_FP          = 16;
  localparam int DEF_H_SYNC        = 96;
  localparam int DEF_H_BP          = 48;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_V_FP          = 10;
  localparam int DEF_V_SYNC        = 2;
  localparam int DEF_V_BP          = 33;
  localparam int DEF_SETTLE_CYCLES = 256;
  localparam int DEF_CODE_W        = 12;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Counters are sized for the standard 800x525 raster.
  localparam int X_W = $clog2(H_TOTAL);
  localparam int Y_W = $clog2(V_TOTAL);

  localparam int BAR_W     = 80;
  localparam int BAR_COUNT = 8;

endpackage

// File: rtl/vga_timing.sv
// Raster position counters with sync, active-area and end-of-frame decode
// of the current position; counters are held at zero while run is low.
module vga_timing
  import dac_seq_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           active,
  output logic           eof
);

  localparam logic [X_W-1:0] H_ACT_END = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEG    = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] H_LAST    = X_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [Y_W-1:0] V_ACT_END = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEG    = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic x_last, y_last;

  assign x_last = (x == H_LAST);
  assign y_last = (y == V_LAST);
  assign eof    = x_last && y_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (!run) begin
      x <= '0;
      y <= '0;
    end else if (x_last) begin
      x <= '0;
      y <= y_last ? '0 : y + Y_W'(1);
    end else begin
      x <= x + X_W'(1);
    end
  end

  assign hsync_n = !((x >= HS_BEG) && (x < HS_END));
  assign vsync_n = !((y >= VS_BEG) && (y < VS_END));
  assign active  = (x < H_ACT_END) && (y < V_ACT_END);

endmodule

// File: rtl/dac_scan_sequencer.sv
// Powers up the shared segdac bias, waits for it to settle, then scans a VGA
// raster and delivers registered per-pixel R/G/B DAC codes with aligned syncs.
module dac_scan_sequencer
  import dac_seq_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_FP          = DEF_H_FP,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BP          = DEF_H_BP,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int V_FP          = DEF_V_FP,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BP          = DEF_V_BP,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CODE_W        = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [2:0]        bias_cfg,
  input  logic [CODE_W-1:0] px_r,
  input  logic [CODE_W-1:0] px_g,
  input  logic [CODE_W-1:0] px_b,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CODE_W-1:0] r_code,
  output logic [CODE_W-1:0] g_code,
  output logic [CODE_W-1:0] b_code,
  output logic [2:0]        bias,
  output logic              ready,
  output logic              frame_start
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  state_t            state_reg;
  logic [SW-1:0]     settle_reg;
  mode_t             mode_reg;
  logic [CODE_W-1:0] solid_r_reg, solid_g_reg, solid_b_reg;

  logic t_hsync_n, t_vsync_n, t_active, t_eof;
  logic eof_run, capture, go_off, settle_done;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .run     (state_reg == RUN),
    .x       (x),
    .y       (y),
    .hsync_n (t_hsync_n),
    .vsync_n (t_vsync_n),
    .active  (t_active),
    .eof     (t_eof)
  );

  assign eof_run     = (state_reg == RUN) && t_eof;
  assign settle_done = (state_reg == SETTLE) && (settle_reg == '0);
  assign capture     = enable && ((state_reg == OFF) || eof_run);
  assign go_off      = !enable && ((state_reg == SETTLE) || eof_run);

  // Bar index is the number of bar boundaries at or left of x.
  logic [BAR_COUNT-2:0] bar_ge;
  logic [2:0]           bar_idx, bar_c;

  for (genvar gi = 1; gi < BAR_COUNT; gi++) begin : g_bar
    assign bar_ge[gi-1] = (x >= X_W'(gi * BAR_W));
  end

  always_comb begin
    bar_idx = '0;
    for (int k = 0; k < BAR_COUNT - 1; k++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[k]};
    end
    bar_c = 3'd7 - bar_idx;
  end

  logic [CODE_W-1:0] ramp, pat_r, pat_g, pat_b;

  assign ramp = CODE_W'({x, x[X_W-1 -: 2]});

  always_comb begin
    pat_r = px_r;
    pat_g = px_g;
    pat_b = px_b;
    unique case (mode_reg)
      MODE_RAMP: begin
        pat_r = ramp;
        pat_g = ramp;
        pat_b = ramp;
      end
      MODE_BARS: begin
        pat_r = bar_c[2] ? '1 : '0;
        pat_g = bar_c[1] ? '1 : '0;
        pat_b = bar_c[0] ? '1 : '0;
      end
      MODE_SOLID: begin
        pat_r = solid_r_reg;
        pat_g = solid_g_reg;
        pat_b = solid_b_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= OFF;
      settle_reg  <= '0;
      ready       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      unique case (state_reg)
        OFF: begin
          if (enable) begin
            state_reg  <= SETTLE;
            settle_reg <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state_reg <= OFF;
          end else if (settle_done) begin
            state_reg   <= RUN;
            ready       <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            settle_reg <= settle_reg - SW'(1);
          end
        end
        RUN: begin
          // Shutdown is only honoured at the frame boundary.
          if (t_eof) begin
            if (!enable) begin
              state_reg <= OFF;
              ready     <= 1'b0;
            end else begin
              frame_start <= 1'b1;
            end
          end
        end
        default: state_reg <= OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg    <= MODE_EXT;
      bias        <= '0;
      solid_r_reg <= '0;
      solid_g_reg <= '0;
      solid_b_reg <= '0;
    end else if (capture) begin
      mode_reg    <= mode_t'(mode);
      bias        <= bias_cfg;
      solid_r_reg <= px_r;
      solid_g_reg <= px_g;
      solid_b_reg <= px_b;
    end else if (go_off) begin
      bias <= '0;
    end
  end

  // One-cycle output stage: codes and syncs for position (x,y) appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      de     <= 1'b0;
      r_code <= '0;
      g_code <= '0;
      b_code <= '0;
    end else if (state_reg == RUN) begin
      hsync  <= t_hsync_n;
      vsync  <= t_vsync_n;
      de     <= t_active;
      r_code <= t_active ? pat_r : '0;
      g_code <= t_active ? pat_g : '0;
      b_code <= t_active ? pat_b : '0;
    end else begin
      hsync  <= 1'b1;
      vsync  <= 1'b1;
      de     <= 1'b0;
      r_code <= '0;
      g_code <= '0;
      b_code <= '0;
    end
  end

endmodule

// File: tb/tb_dac_scan_sequencer.sv
// Randomized scoreboard bench: a frame-position reference model queues the
// expected outputs of every cycle and a monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_dac_scan_sequencer;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 3, VF = 1, VS = 2, VB = 1;
  localparam int ST = 16, CW = 12;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [2:0]    bias_cfg = 3'd0;
  logic [CW-1:0] px_r = '0, px_g = '0, px_b = '0;
  logic [9:0]    x, y;
  logic          hsync, vsync, de, ready, frame_start;
  logic [CW-1:0] r_code, g_code, b_code;
  logic [2:0]    bias;

  always #5 clk = ~clk;

  dac_scan_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SETTLE_CYCLES(ST), .CODE_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .bias_cfg(bias_cfg),
    .px_r(px_r), .px_g(px_g), .px_b(px_b),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de),
    .r_code(r_code), .g_code(g_code), .b_code(b_code),
    .bias(bias), .ready(ready), .frame_start(frame_start)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] r;
    logic [11:0] g;
    logic [11:0] b;
    logic [2:0]  bias;
    logic        rdy;
    logic        fs;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: phase 0 off, 1 settling, 2 scanning; pix is the
  // linear position within the frame.
  int m_ph = 0, m_left = 0, m_pix = 0;
  int sh_mode = 0, sh_bias = 0, sh_r = 0, sh_g = 0, sh_b = 0;

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  task automatic capture_shadows();
    sh_mode = int'(mode);
    sh_bias = int'(bias_cfg);
    sh_r = int'(px_r);
    sh_g = int'(px_g);
    sh_b = int'(px_b);
  endtask

  always @(negedge clk) begin
    obs_t e;
    int cx, cy, c, v;
    e = idle_obs();
    if (rst) begin
      m_ph = 0; m_left = 0; m_pix = 0;
      sh_mode = 0; sh_bias = 0; sh_r = 0; sh_g = 0; sh_b = 0;
    end else begin
      if (m_ph == 2) begin
        cx = m_pix % HT;
        cy = m_pix / HT;
        e.de = (cx < HA) && (cy < VA);
        e.hs = !((cx >= HA + HF) && (cx < HA + HF + HS));
        e.vs = !((cy >= VA + VF) && (cy < VA + VF + VS));
        if (e.de) begin
          case (sh_mode)
            1: begin
              v = cx * 4 + cx / 256;
              e.r = 12'(v); e.g = 12'(v); e.b = 12'(v);
            end
            2: begin
              c = 7 - cx / 80;
              e.r = (c & 4) != 0 ? 12'hFFF : 12'h000;
              e.g = (c & 2) != 0 ? 12'hFFF : 12'h000;
              e.b = (c & 1) != 0 ? 12'hFFF : 12'h000;
            end
            3: begin
              e.r = 12'(sh_r); e.g = 12'(sh_g); e.b = 12'(sh_b);
            end
            default: begin
              e.r = px_r; e.g = px_g; e.b = px_b;
            end
          endcase
        end
      end
      case (m_ph)
        0: if (enable) begin
          m_ph = 1;
          m_left = ST;
          capture_shadows();
        end
        1: if (!enable) begin
          m_ph = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_ph = 2;
            m_pix = 0;
          end
        end
        default: begin
          m_pix++;
          if (m_pix == FRAME) begin
            m_pix = 0;
            if (!enable) m_ph = 0;
            else capture_shadows();
          end
        end
      endcase
      e.x    = (m_ph == 2) ? 10'(m_pix % HT) : 10'd0;
      e.y    = (m_ph == 2) ? 10'(m_pix / HT) : 10'd0;
      e.bias = (m_ph == 0) ? 3'd0 : 3'(sh_bias);
      e.rdy  = (m_ph == 2);
      e.fs   = (m_ph == 2) && (m_pix == 0);
    end
    exp_q.push_back(e);
  end

  function automatic obs_t dut_obs();
    return {x, y, hsync, vsync, de, r_code, g_code, b_code, bias, ready, frame_start};
  endfunction

  task automatic report(input string name, input obs_t a, input obs_t e);
    $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b rgb=%h/%h/%h bias=%b rdy=%b fs=%b, required x=%0d y=%0d hs=%b vs=%b de=%b rgb=%h/%h/%h bias=%b rdy=%b fs=%b",
             name, $time, a.x, a.y, a.hs, a.vs, a.de, a.r, a.g, a.b, a.bias, a.rdy, a.fs,
             e.x, e.y, e.hs, e.vs, e.de, e.r, e.g, e.b, e.bias, e.rdy, e.fs);
  endtask

  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_obs();
      vectors++;
      if (a !== e) begin
        miscompares++;
        report("cycle_outputs", a, e);
      end
    end
  end

  logic px_rand = 1'b1;
  always @(posedge clk) begin
    #2;
    if (px_rand) begin
      px_r = 12'($urandom);
      px_g = 12'($urandom);
      px_b = 12'($urandom);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pix(input int target, input int budget, input string what);
    int k;
    k = 0;
    while (!(m_ph == 2 && m_pix == target) && k < budget) begin
      step(1);
      k++;
    end
    if (!(m_ph == 2 && m_pix == target)) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: position %0d not reached within %0d cycles (phase %0d)", what, target, budget, m_ph);
    end
  endtask

  task automatic wait_phase(input int ph, input int budget, input string what);
    int k;
    k = 0;
    while (m_ph != ph && k < budget) begin
      step(1);
      k++;
    end
    if (m_ph != ph) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_%s: phase %0d not reached within %0d cycles (phase %0d)", what, ph, budget, m_ph);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t a;
    step(3);
    rst = 1'b0;
    $display("txn reset_idle: enable low for 100 clocks, random mode/bias_cfg");
    repeat (100) begin
      mode = 2'($urandom);
      bias_cfg = 3'($urandom);
      step(1);
    end

    $display("txn power_up: bias_cfg=101 mode=ramp");
    enable = 1'b1; bias_cfg = 3'b101; mode = 2'd1;
    step(1);
    bias_cfg = 3'($urandom);
    mode = 2'($urandom);
    wait_phase(2, ST + 4, "run_ramp");
    wait_pix(HT + 5, FRAME, "ramp_line1");
    $display("txn mode_to_bars mid-frame");
    mode = 2'd2; bias_cfg = 3'($urandom);
    wait_pix(0, FRAME + 10, "bars_frame");
    wait_pix(2 * HT, FRAME, "bars_line2");
    $display("txn mode_to_solid mid-frame");
    mode = 2'd3; bias_cfg = 3'($urandom);
    wait_pix(0, FRAME + 10, "solid_frame");
    wait_pix(HT + 100, FRAME, "solid_line1");
    $display("txn mode_to_external mid-frame");
    mode = 2'd0; bias_cfg = 3'($urandom);
    wait_pix(0, FRAME + 10, "ext_frame");
    wait_pix(HT + 7, FRAME, "ext_line1");
    $display("txn shutdown mid-frame");
    enable = 1'b0; mode = 2'($urandom);
    wait_phase(0, FRAME + 10, "off_after_frame");
    step(20);

    $display("txn settle_abort");
    enable = 1'b1; bias_cfg = 3'($urandom);
    step(5);
    enable = 1'b0;
    step(10);

    $display("txn shutdown_cancel: enable blip inside frame");
    enable = 1'b1; mode = 2'd2; bias_cfg = 3'($urandom);
    wait_phase(2, ST + 4, "run_bars");
    wait_pix(HT + 3, FRAME, "cancel_line1");
    enable = 1'b0;
    step(50);
    enable = 1'b1;
    wait_pix(0, FRAME + 10, "wrap_kept_running");
    wait_pix(HT + 20, FRAME, "pre_reset");

    $display("txn async_reset mid-run");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    a = dut_obs();
    vectors++;
    if (a !== idle_obs()) begin
      miscompares++;
      report("async_reset", a, idle_obs());
    end
    step(2);
    rst = 1'b0;
    mode = 2'($urandom);
    wait_phase(2, ST + 6, "run_after_reset");
    step(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
